// File: rtl/prio_enc_pkg.sv
// Shared helpers for the priority event encoder: index width, one-hot to binary, default line count.
package prio_enc_pkg;

    localparam int DEFAULT_N = 8;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // OR-reduction form keeps this a flat mux-free encoder for a true one-hot input.
    function automatic logic [5:0] onehot_to_idx(input logic [63:0] oh);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < 64; i++) begin
            if (oh[i]) idx |= 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Find-first-set over vec, searching upward from (base+1) mod N with wrap.
// Purely combinational; no backpressure of its own.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] base,
    output logic [W-1:0] sel,
    output logic         any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   low;
    int             start;

    // Rotate so the search origin lands on bit 0, isolate the lowest set bit, then rotate the index back.
    always_comb begin
        start = (int'(base) + 1) % N;
        dbl   = {vec, vec} >> start;
        rot   = dbl[N-1:0];
        low   = rot & (-rot);
        sel   = W'((int'(onehot_to_idx(64'(low))) + start) % N);
        any   = |vec;
    end

endmodule

// File: rtl/prio_event_encoder.sv
// Captures event pulses into a pending register and serialises their indices on a valid/ready port; 2-cycle latency, slot holds while !out_ready.
// PRIO_ROUND_ROBIN_EN selects round-robin search from the last granted line; default is fixed lowest-index priority.
module prio_event_encoder
    import prio_enc_pkg::*;
#(
    parameter int  N = DEFAULT_N,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         ovf
);

    logic [N-1:0] p;
    logic [N-1:0] elig;
    logic [N-1:0] load_oh;
    logic [W-1:0] sel;
    logic [W-1:0] base;
    logic         any;
    logic         load;

    assign elig    = p & mask;
    assign load    = (!out_valid || out_ready) && any;
    assign pending = p;

    prio_pick #(.N(N), .W(W)) u_pick (
        .vec  (elig),
        .base (base),
        .sel  (sel),
        .any  (any)
    );

    always_comb begin
        load_oh = '0;
        if (load) load_oh[sel] = 1'b1;
    end

`ifdef PRIO_ROUND_ROBIN_EN
    logic [W-1:0] ptr;

    assign base = ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= W'(N - 1);
        end else if (load) begin
            ptr <= sel;
        end
    end
`else
    assign base = W'(N - 1);
`endif

    // A request landing on the line being moved to the slot is a fresh event, not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            p   <= (p & ~load_oh) | req;
            ovf <= |(req & p & ~load_oh);
            if (load) begin
                out_valid <= 1'b1;
                out_idx   <= sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prio_event_encoder.sv
// Randomised and directed checks of prio_event_encoder against an event-level reference model.
module tb_prio_event_encoder;
    import prio_enc_pkg::*;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] mask = '1;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] pending;
    logic         ovf;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model state: set of pending lines, presented slot, overrun pulse, last grant.
    bit m_p[N];
    bit m_vld;
    bit m_ovf;
    int m_idx;
    int m_ptr;

    prio_event_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pending   (pending),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_p[i] = 1'b0;
        m_vld = 1'b0;
        m_ovf = 1'b0;
        m_idx = 0;
        m_ptr = N - 1;
    endtask

    function automatic int model_pick();
        int i;
        for (int k = 1; k <= N; k++) begin
`ifdef PRIO_ROUND_ROBIN_EN
            i = (m_ptr + k) % N;
`else
            i = k - 1;
`endif
            if (m_p[i] && mask[i]) return i;
        end
        return -1;
    endfunction

    task automatic compare();
        logic [N-1:0] pv;
        for (int i = 0; i < N; i++) pv[i] = m_p[i];
        check("valid", 64'(out_valid), 64'(m_vld));
        check("idx", 64'(out_idx), 64'(m_idx));
        check("pending", 64'(pending), 64'(pv));
        check("ovf", 64'(ovf), 64'(m_ovf));
    endtask

    // Advance one clock with the currently driven inputs, updating the model alongside the DUT.
    task automatic tick();
        int s;
        bit np[N];
        bit no;
        s  = (!m_vld || out_ready) ? model_pick() : -1;
        no = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && m_p[i] && i != s) no = 1'b1;
            np[i] = (m_p[i] && i != s) || req[i];
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) m_p[i] = np[i];
        m_ovf = no;
        if (s >= 0) begin
            m_vld = 1'b1;
            m_idx = s;
            m_ptr = s;
        end else if (out_ready) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
        compare();
    endtask

    initial begin
        int exp_seq[4];
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_idx", 64'(out_idx), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;

        // Single pulse on line 5
        req = 8'h20; tick();
        req = 8'h00; tick();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_idx", 64'(out_idx), 64'd5);
        tick();
        check("single_done", 64'(out_valid), 64'd0);
        check("single_pend", 64'(pending), 64'd0);

        // Three simultaneous events drain lowest first
        req = 8'h91; tick();
        req = 8'h00;
        exp_seq = '{0, 4, 7, 0};
        for (int k = 0; k < 3; k++) begin
            tick();
            check("multi_idx", 64'(out_idx), 64'(exp_seq[k]));
        end
        tick();
        check("multi_done", 64'(out_valid), 64'd0);

        // Backpressure hold and overrun
        req = 8'h08; tick();
        req = 8'h00; out_ready = 1'b0; tick();
        check("bp_load", 64'(out_idx), 64'd3);
        for (int k = 0; k < 5; k++) begin
            req = (k == 1 || k == 2) ? 8'h08 : 8'h00;
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_idx", 64'(out_idx), 64'd3);
            check("bp_ovf", 64'(ovf), (k == 2) ? 64'd1 : 64'd0);
        end
        req = 8'h00; out_ready = 1'b1; tick();
        check("bp_reload", 64'(out_idx), 64'd3);
        tick();
        check("bp_done", 64'(out_valid), 64'd0);

        // Masked events stay pending until unmasked
        mask = 8'h0F; req = 8'hF0; tick();
        req = 8'h00; tick(); tick();
        check("mask_valid", 64'(out_valid), 64'd0);
        check("mask_pend", 64'(pending), 64'hF0);
        mask = 8'hFF;
        exp_seq = '{4, 5, 6, 7};
        for (int k = 0; k < 4; k++) begin
            tick();
            check("unmask_idx", 64'(out_idx), 64'(exp_seq[k]));
        end
        tick();

        // Asynchronous reset mid-stream
        req = 8'h05; tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_idx", 64'(out_idx), 64'd0);
        check("arst_pending", 64'(pending), 64'd0);
        check("arst_ovf", 64'(ovf), 64'd0);
        model_reset();
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;

        // Continuously held requests on lines 0 and 2
        req = 8'h05; tick();
`ifdef PRIO_ROUND_ROBIN_EN
        exp_seq = '{0, 2, 0, 2};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            tick();
            check("held_idx", 64'(out_idx), 64'(exp_seq[k]));
        end
        req = 8'h00;
        repeat (4) tick();

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            req       = N'($urandom & $urandom & $urandom);
            mask      = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req = 8'h00; mask = 8'hFF; out_ready = 1'b1;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prio_event_encoder.md
# prio_event_encoder

Parametrised, registered successor to the 8-to-3 one-hot encoder. Captures event pulses on N request lines into a pending register and emits their binary indices one at a time on a valid/ready output, highest priority first. Sits between raw event/interrupt sources and any consumer that needs a serialised index stream. Adds masking and overrun detection, and unlike the one-hot encoder it handles multiple simultaneous requests with no undefined output.

## Interface
- N, default 8: number of request lines, 2..64.
- W, default $clog2(N): index width. Derived, never overridden.

- CLK, input, 1: the block's single clock. All state updates on the rising edge.
- RST_N, input, 1: asynchronous, active-low reset.
- REQ, input, N: event pulses. A 1 on bit i in any cycle records one event for i.
- MASK, input, N: bit i = 1 makes line i eligible for selection. Masked events stay pending.
- OUT_VALID, output, 1: OUT_IDX holds an index awaiting acceptance.
- OUT_READY, input, 1: the consumer accepts when OUT_VALID && OUT_READY at a rising edge.
- OUT_IDX, output, W: binary index of the presented event.
- PENDING, output, N: current pending register, for status reads.
- OVF, output, 1: one-cycle pulse when an event hits a line that is already pending.

## Operation
- State:
  - Pending register P[N-1:0].
  - Output slot: OUT_VALID and OUT_IDX.
  - Overrun flag OVF.
  - RR pointer PTR[W-1:0], present only with the macro.
- Slot load condition: load = (!OUT_VALID || OUT_READY) && |(P & MASK).
- On load:
  - OUT_IDX <= sel, where sel is the selected index of P & MASK.
  - OUT_VALID <= 1.
  - P[sel] is cleared; the event moves into the slot.
- When accepted with no load: OUT_VALID <= 0.
- When OUT_VALID && !OUT_READY: OUT_IDX and OUT_VALID hold stable. No change is allowed while the slot is waiting.
- P update each cycle: P_next = (P & ~load_onehot) | REQ.
  - If REQ[i] arrives in the same cycle that P[i] moves to the slot, P[i] stays 1. This counts as a new event, not an overrun.
- Overrun: OVF <= |(REQ & P & ~load_onehot). The duplicate event is dropped; P is already 1.
- Fixed priority: the lowest set index wins.
- Masking:
  - MASK changes take effect on the next load decision.
  - Clearing a MASK bit never retracts an index already in the slot.
- No undefined output. When OUT_VALID = 0, OUT_IDX holds its last value (0 after reset).

## Timing
- Reset values: P = 0, OUT_VALID = 0, OUT_IDX = 0, OVF = 0, PENDING = 0, PTR = N-1.
- Reset is asynchronous. Asserting it mid-transfer drops all pending and presented events immediately.
- Latency: REQ sampled at edge k sets P after edge k. OUT_VALID rises after edge k+1, so 2 cycles.
- Throughput: one index per cycle while OUT_READY = 1 and eligible events remain.
- OVF is registered. It is high for exactly the cycle after the offending edge.
- PENDING is a registered copy of P, with no combinational path from REQ.

## Configuration
- PRIO_ROUND_ROBIN_EN defined:
  - The search starts at (PTR+1) mod N and wraps upward.
  - On each load, PTR <= sel.
  - With PTR at its reset value of N-1, the first search is identical to fixed priority.
- PRIO_ROUND_ROBIN_EN undefined:
  - Fixed lowest-index priority.
  - The PTR register is absent.

## Structure
- Package prio_enc_pkg holds:
  - the index-width helper function;
  - the onehot-to-index function;
  - the default-N constant.
- Sub-module prio_pick: combinational find-first-set over an N-bit vector with a rotation base input. It outputs sel and any. Without the macro, the base is tied to N-1.
- The top level holds P, the output slot, OVF and PTR.

## Test plan
All scenarios use N = 8 and MASK = 8'hFF unless stated.

1. Reset, idle: OUT_VALID = 0, OUT_IDX = 0, PENDING = 0, OVF = 0. RST_N asserted mid-stream clears everything asynchronously.
2. Single pulse REQ = 8'h20 for one cycle, OUT_READY = 1: OUT_VALID is high for one cycle with OUT_IDX = 5, two edges after the pulse. PENDING then returns to 0.
3. REQ = 8'h91 in one cycle, OUT_READY = 1, fixed priority: OUT_IDX sequence is 0, 4, 7 on consecutive cycles.
4. Backpressure with OUT_READY = 0 for 5 cycles while OUT_IDX = 3: OUT_IDX and OUT_VALID stay stable. A second REQ[3] pulse in that window gives OVF = 1 for one cycle, because P[3] is set again after the load and the duplicate is dropped.
5. MASK = 8'h0F, REQ = 8'hF0: OUT_VALID stays 0 and PENDING = 8'hF0. Raising MASK to 8'hFF drains the indices 4, 5, 6, 7.
6. With PRIO_ROUND_ROBIN_EN, REQ held at 8'h05 continuously and OUT_READY = 1: OUT_IDX alternates 0, 2, 0, 2. Without the macro, OUT_IDX stays 0 every cycle and line 2 starves.
